// File: rtl/trade_report_framer_pkg.sv
// Shared constants, trade entry layout and frame byte selection for the trade report framer.
package trade_report_framer_pkg;

  localparam int unsigned FRAME_LEN = 12;
  localparam int unsigned SEQ_HI    = 1;
  localparam int unsigned TS_0      = 3;
  localparam int unsigned INFO_0    = 7;
  localparam int unsigned CHK       = 11;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned SEQ_W     = 16;
  localparam int unsigned TS_W      = 32;
  localparam int unsigned INFO_W    = 32;
  localparam int unsigned ENTRY_W   = 80;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  // One buffered trade: stamped sequence, timestamp and the opaque trade word.
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [TS_W-1:0]   ts;
    logic [INFO_W-1:0] info;
  } trade_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte idx of the serialised frame; the checksum is derived from the same bytes.
  function automatic logic [7:0] frame_byte(input trade_entry_t e, input logic [IDX_W-1:0] idx);
    logic [7:0] b [FRAME_LEN];
    logic [7:0] r;
    b[0]          = SOF_BYTE;
    b[SEQ_HI]     = e.seq[15:8];
    b[SEQ_HI+1]   = e.seq[7:0];
    b[TS_0]       = e.ts[31:24];
    b[TS_0+1]     = e.ts[23:16];
    b[TS_0+2]     = e.ts[15:8];
    b[TS_0+3]     = e.ts[7:0];
    b[INFO_0]     = e.info[31:24];
    b[INFO_0+1]   = e.info[23:16];
    b[INFO_0+2]   = e.info[15:8];
    b[INFO_0+3]   = e.info[7:0];
    b[CHK]        = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7] ^ b[8] ^ b[9] ^ b[10];
    r = 8'h00;
    if (idx < IDX_W'(FRAME_LEN)) r = b[idx];
    return r;
  endfunction

endpackage

// File: rtl/trade_report_framer_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty; read data is the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata_c,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_d;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level_d = level + LW'(do_push) - LW'(do_pop);
  assign rdata_c = mem[rd_ptr];

  // Storage array; no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

endmodule

// File: rtl/trade_report_framer.sv
// Stamps trade pulses with sequence/timestamp, buffers them and streams 12-byte frames.
module trade_report_framer
  import trade_report_framer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trade_valid,
  input  logic [31:0]                  trade_info,
  output logic [7:0]                   m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [CNT_WIDTH-1:0]         overflow_count
);

  logic [SEQ_W-1:0]   seq_q;
  logic [TS_W-1:0]    ts_q;
  trade_entry_t       cap_entry;
  logic [ENTRY_W-1:0] fifo_rdata_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  trade_entry_t       frame_q, frame_d;
  logic               m_valid_d;
  logic               m_last_d;
  logic [7:0]         m_data_d;

  assign cap_entry = '{seq: seq_q, ts: ts_q, info: trade_info};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (trade_valid),
    .wdata   (cap_entry),
    .pop     (fifo_pop),
    .rdata_c (fifo_rdata_c),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Free-running timestamp, per-pulse sequence and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q           <= '0;
      seq_q          <= '0;
      overflow_count <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (trade_valid) seq_q <= seq_q + SEQ_W'(1);
      if (trade_valid && fifo_full && (overflow_count != '1))
        overflow_count <= overflow_count + CNT_WIDTH'(1);
    end
  end

  // Framer state, byte index, frame register and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      m_valid <= m_valid_d;
      m_last  <= m_last_d;
      m_data  <= m_data_d;
    end
  end

  // Next state: pop one entry when idle, walk the 12 bytes on handshakes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          frame_d  = trade_entry_t'(fifo_rdata_c);
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (idx_q == IDX_W'(CHK)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    m_valid_d = (state_d == SEND);
    m_last_d  = m_valid_d && (idx_d == IDX_W'(CHK));
    m_data_d  = m_valid_d ? frame_byte(frame_d, idx_d) : 8'h00;
  end

endmodule
